flashmem_emulator: RTL and testbench

//  Synthesizable responder for the FM_* flash-memory interface driven by flashmem_controller.

---
 rtl/flashmem_emulator.sv | 248 ++++++++++++++++++++++++
 tb/tb_flashmem_emulator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flashmem_emulator.sv
// Block-RAM stand-in for the NVM hard block on the FM_* bus: one-page write buffer, program copy-back, busy timing.
// Optional feature: define FM_EMU_PAGESTATUS_EN to enable the FM_PAGESTATUS dirty/open-page query.
module flashmem_emulator #(
    parameter int MEM_AW     = 12,
    parameter int PAGE_AW    = 6,
    parameter int READ_WAIT  = 5,
    parameter int WRITE_WAIT = 10,
    parameter int PROG_WAIT  = 850
) (
    input  logic        FM_CLK,
    input  logic        reset,
    input  logic [16:0] FM_ADDR,
    input  logic [15:0] FM_WD,
    input  logic        FM_REN,
    input  logic        FM_WEN,
    input  logic        FM_PROGRAM,
    input  logic        FM_PAGESTATUS,
    output logic [15:0] FM_RD,
    output logic        FM_BUSY,
    output logic [1:0]  FM_STATUS
);

    localparam int PG_W   = 17 - PAGE_AW;
    localparam int MAXW1  = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int MAXW   = (PROG_WAIT > MAXW1) ? PROG_WAIT : MAXW1;
    localparam int CNT_W  = $clog2(MAXW + 2);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_WCONF    = 2'b01;
    localparam logic [1:0] ST_NODIRTY  = 2'b10;
    localparam logic [1:0] ST_MISMATCH = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ_W,
        LOAD,
        WRITE_W,
        REJECT,
        PROG_COPY,
        PROG_W,
        PSTAT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PAGE_AW-1:0]  idx_q, idx_d;
    logic [16:0]         addr_q, addr_d;
    logic [15:0]         wd_q, wd_d;
    logic [PG_W-1:0]     openPage_q, openPage_d;
    logic                dirty_q, dirty_d;
    logic [15:0]         rd_q, rd_d;
    logic [1:0]          status_q, status_d;
    logic [1:0]          pend_q, pend_d;

    logic [15:0]         mem [0:(1<<MEM_AW)-1];
    logic [15:0]         pageBuf [0:(1<<PAGE_AW)-1];
    logic [15:0]         ramRData_q;
    logic [MEM_AW-1:0]   ramRAddr;
    logic [MEM_AW-1:0]   ramWAddr;
    logic [15:0]         ramWData;
    logic                ramWe;
    logic [PAGE_AW-1:0]  bufWAddr;
    logic [15:0]         bufWData;
    logic                bufWe;

    logic [PG_W-1:0]     cmdPage;
    logic [PG_W-1:0]     addrPage;
    logic [PAGE_AW-1:0]  addrOff;
    logic [PAGE_AW-1:0]  idxNext;

    assign cmdPage  = FM_ADDR[16:PAGE_AW];
    assign addrPage = addr_q[16:PAGE_AW];
    assign addrOff  = addr_q[PAGE_AW-1:0];
    assign idxNext  = idx_q + 1'b1;

    assign FM_RD     = rd_q;
    assign FM_BUSY   = (state_q != IDLE);
    assign FM_STATUS = status_q;

    // Synchronous-read backing store; the read address is steered so data is ready one cycle ahead of use.
    always_ff @(posedge FM_CLK) begin
        if (ramWe) begin
            mem[ramWAddr] <= ramWData;
        end
        ramRData_q <= mem[ramRAddr];
    end

    always_ff @(posedge FM_CLK) begin
        if (bufWe) begin
            pageBuf[bufWAddr] <= bufWData;
        end
    end

    always_ff @(posedge FM_CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            openPage_q <= '0;
            dirty_q    <= 1'b0;
            rd_q       <= '0;
            status_q   <= ST_OK;
            pend_q     <= ST_OK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            openPage_q <= openPage_d;
            dirty_q    <= dirty_d;
            rd_q       <= rd_d;
            status_q   <= status_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        openPage_d = openPage_q;
        dirty_d    = dirty_q;
        rd_d       = rd_q;
        status_d   = status_q;
        pend_d     = pend_q;
        ramRAddr   = MEM_AW'(addr_q);
        ramWe      = 1'b0;
        ramWAddr   = MEM_AW'({openPage_q, idx_q});
        ramWData   = pageBuf[idx_q];
        bufWe      = 1'b0;
        bufWAddr   = idx_q;
        bufWData   = ramRData_q;

        case (state_q)
            IDLE: begin
                // Prefetch either the read word or word 0 of the target page for a LOAD.
                ramRAddr = FM_REN ? MEM_AW'(FM_ADDR) : MEM_AW'({cmdPage, {PAGE_AW{1'b0}}});
                if (FM_REN) begin
                    addr_d  = FM_ADDR;
                    cnt_d   = CNT_W'(READ_WAIT);
                    state_d = READ_W;
                end else if (FM_WEN) begin
                    addr_d = FM_ADDR;
                    wd_d   = FM_WD;
                    if (dirty_q && (cmdPage != openPage_q)) begin
                        pend_d  = ST_WCONF;
                        state_d = REJECT;
                    end else if (dirty_q) begin
                        cnt_d   = CNT_W'(WRITE_WAIT);
                        state_d = WRITE_W;
                    end else begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end
                end else if (FM_PROGRAM) begin
                    addr_d = FM_ADDR;
                    if (!dirty_q) begin
                        pend_d  = ST_NODIRTY;
                        cnt_d   = CNT_W'(PROG_WAIT);
                        state_d = PROG_W;
                    end else if (cmdPage != openPage_q) begin
                        pend_d  = ST_MISMATCH;
                        state_d = REJECT;
                    end else begin
                        pend_d  = ST_OK;
                        idx_d   = '0;
                        state_d = PROG_COPY;
                    end
`ifdef FM_EMU_PAGESTATUS_EN
                end else if (FM_PAGESTATUS) begin
                    state_d = PSTAT;
`endif
                end
            end
            READ_W: begin
                if (cnt_q == '0) begin
                    rd_d     = (dirty_q && (addrPage == openPage_q)) ? pageBuf[addrOff] : ramRData_q;
                    status_d = ST_OK;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOAD: begin
                ramRAddr = MEM_AW'({addrPage, idxNext});
                bufWe    = !reset;
                if (idx_q == {PAGE_AW{1'b1}}) begin
                    openPage_d = addrPage;
                    dirty_d    = 1'b1;
                    cnt_d      = CNT_W'(WRITE_WAIT);
                    state_d    = WRITE_W;
                end else begin
                    idx_d = idxNext;
                end
            end
            WRITE_W: begin
                if (cnt_q == '0) begin
                    bufWe    = !reset;
                    bufWAddr = addrOff;
                    bufWData = wd_q;
                    status_d = ST_OK;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            REJECT: begin
                status_d = pend_q;
                state_d  = IDLE;
            end
            PROG_COPY: begin
                // Each word lands in RAM on its own edge, so a reset here leaves a partial program.
                ramWe = !reset;
                if (idx_q == {PAGE_AW{1'b1}}) begin
                    cnt_d   = CNT_W'(PROG_WAIT);
                    state_d = PROG_W;
                end else begin
                    idx_d = idxNext;
                end
            end
            PROG_W: begin
                if (cnt_q == '0) begin
                    dirty_d  = 1'b0;
                    status_d = pend_q;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef FM_EMU_PAGESTATUS_EN
            PSTAT: begin
                rd_d     = {dirty_q, 4'b0000, 11'(openPage_q)};
                status_d = ST_OK;
                state_d  = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flashmem_emulator.sv
// Directed self-checking bench for flashmem_emulator: busy timing, buffer/RAM readback, program and error statuses.
module tb_flashmem_emulator;

    logic        FM_CLK = 1'b0;
    logic        reset;
    logic [16:0] FM_ADDR;
    logic [15:0] FM_WD;
    logic        FM_REN;
    logic        FM_WEN;
    logic        FM_PROGRAM;
    logic        FM_PAGESTATUS;
    logic [15:0] FM_RD;
    logic        FM_BUSY;
    logic [1:0]  FM_STATUS;

    int nChecks = 0;
    int nFail   = 0;

    flashmem_emulator dut (
        .FM_CLK(FM_CLK),
        .reset(reset),
        .FM_ADDR(FM_ADDR),
        .FM_WD(FM_WD),
        .FM_REN(FM_REN),
        .FM_WEN(FM_WEN),
        .FM_PROGRAM(FM_PROGRAM),
        .FM_PAGESTATUS(FM_PAGESTATUS),
        .FM_RD(FM_RD),
        .FM_BUSY(FM_BUSY),
        .FM_STATUS(FM_STATUS)
    );

    always #5 FM_CLK = ~FM_CLK;

    // Issue one command for a single edge, then count the negedges on which FM_BUSY stays high.
    task automatic doCmd(input logic ren, input logic wen, input logic prog, input logic ps,
                         input logic [16:0] addr, input logic [15:0] wd, output int busyCycles);
        @(negedge FM_CLK);
        FM_ADDR = addr; FM_WD = wd;
        FM_REN = ren; FM_WEN = wen; FM_PROGRAM = prog; FM_PAGESTATUS = ps;
        @(posedge FM_CLK);
        #1;
        FM_REN = 1'b0; FM_WEN = 1'b0; FM_PROGRAM = 1'b0; FM_PAGESTATUS = 1'b0;
        busyCycles = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge FM_CLK);
            if (!FM_BUSY) return;
            busyCycles++;
        end
        busyCycles = -1;
    endtask

    task automatic writeWord(input logic [16:0] addr, input logic [15:0] d, output int bc);
        doCmd(1'b0, 1'b1, 1'b0, 1'b0, addr, d, bc);
    endtask

    task automatic readWord(input logic [16:0] addr, output logic [15:0] d, output int bc);
        doCmd(1'b1, 1'b0, 1'b0, 1'b0, addr, 16'h0, bc);
        d = FM_RD;
    endtask

    task automatic progPage(input logic [16:0] addr, output int bc);
        doCmd(1'b0, 1'b0, 1'b1, 1'b0, addr, 16'h0, bc);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        FM_ADDR = '0; FM_WD = '0;
        FM_REN = 1'b0; FM_WEN = 1'b0; FM_PROGRAM = 1'b0; FM_PAGESTATUS = 1'b0;
        repeat (3) @(posedge FM_CLK);
        #1 reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge FM_CLK);
            nChecks++;
            if (FM_BUSY !== 1'b0 || FM_STATUS !== 2'b00 || FM_RD !== 16'h0) begin
                nFail++;
                $display("[TB] FAIL reset_idle cyc=%0d busy=%b status=%b rd=%h exp 0/00/0000", i, FM_BUSY, FM_STATUS, FM_RD);
            end
        end
    endtask

    task automatic test_write_read_buffer;
        int bc; logic [15:0] d;
        writeWord(17'd64, 16'h1234, bc);
        nChecks++;
        if (bc !== 75) begin nFail++; $display("[TB] FAIL write_clean_busy got=%0d exp=75", bc); end
        nChecks++;
        if (FM_STATUS !== 2'b00) begin nFail++; $display("[TB] FAIL write_clean_status got=%b exp=00", FM_STATUS); end
        readWord(17'd64, d, bc);
        nChecks++;
        if (bc !== 6) begin nFail++; $display("[TB] FAIL read_busy got=%0d exp=6", bc); end
        nChecks++;
        if (d !== 16'h1234) begin nFail++; $display("[TB] FAIL read_buffer got=%h exp=1234", d); end
    endtask

    task automatic test_program_page;
        int bc; int bad; logic [15:0] d;
        for (int i = 0; i < 64; i++) begin
            writeWord(17'(64 + i), 16'(i), bc);
            if (i == 0) begin
                nChecks++;
                if (bc !== 11) begin nFail++; $display("[TB] FAIL write_dirty_busy got=%0d exp=11", bc); end
            end
        end
        progPage(17'd64, bc);
        nChecks++;
        if (bc !== 915) begin nFail++; $display("[TB] FAIL program_busy got=%0d exp=915", bc); end
        nChecks++;
        if (FM_STATUS !== 2'b00) begin nFail++; $display("[TB] FAIL program_status got=%b exp=00", FM_STATUS); end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            readWord(17'(64 + i), d, bc);
            if (d !== 16'(i)) bad++;
        end
        nChecks++;
        if (bad !== 0) begin nFail++; $display("[TB] FAIL program_readback bad_words=%0d exp=0", bad); end
        progPage(17'd64, bc);
        nChecks++;
        if (FM_STATUS !== 2'b10 || bc !== 851) begin
            nFail++; $display("[TB] FAIL program_clears_dirty status=%b busy=%0d exp 10/851", FM_STATUS, bc);
        end
    endtask

    task automatic test_conflict;
        int bc; logic [15:0] d;
        writeWord(17'd200, 16'hBEEF, bc);
        progPage(17'd200, bc);
        nChecks++;
        if (FM_STATUS !== 2'b00) begin nFail++; $display("[TB] FAIL conflict_setup_status got=%b exp=00", FM_STATUS); end
        writeWord(17'd64, 16'h5555, bc);
        writeWord(17'd200, 16'hAAAA, bc);
        nChecks++;
        if (FM_STATUS !== 2'b01 || bc !== 1) begin
            nFail++; $display("[TB] FAIL write_conflict status=%b busy=%0d exp 01/1", FM_STATUS, bc);
        end
        readWord(17'd200, d, bc);
        nChecks++;
        if (d !== 16'hBEEF) begin nFail++; $display("[TB] FAIL conflict_ram_unchanged got=%h exp=beef", d); end
        readWord(17'd64, d, bc);
        nChecks++;
        if (d !== 16'h5555) begin nFail++; $display("[TB] FAIL conflict_buffer_kept got=%h exp=5555", d); end
        readWord(17'd65, d, bc);
        nChecks++;
        if (d !== 16'h0001) begin nFail++; $display("[TB] FAIL load_copied_page got=%h exp=0001", d); end
    endtask

    task automatic test_program_errors;
        int bc; logic [15:0] d;
        progPage(17'd300, bc);
        nChecks++;
        if (FM_STATUS !== 2'b11 || bc !== 1) begin
            nFail++; $display("[TB] FAIL program_mismatch status=%b busy=%0d exp 11/1", FM_STATUS, bc);
        end
        readWord(17'd64, d, bc);
        nChecks++;
        if (d !== 16'h5555) begin nFail++; $display("[TB] FAIL mismatch_still_dirty got=%h exp=5555", d); end
        progPage(17'd64, bc);
        nChecks++;
        if (FM_STATUS !== 2'b00 || bc !== 915) begin
            nFail++; $display("[TB] FAIL program_second status=%b busy=%0d exp 00/915", FM_STATUS, bc);
        end
        progPage(17'd64, bc);
        nChecks++;
        if (FM_STATUS !== 2'b10) begin nFail++; $display("[TB] FAIL program_nodirty got=%b exp=10", FM_STATUS); end
        readWord(17'd64, d, bc);
        nChecks++;
        if (d !== 16'h5555) begin nFail++; $display("[TB] FAIL nodirty_ram_unchanged got=%h exp=5555", d); end
    endtask

    task automatic test_priority;
        int bc; logic [15:0] d;
        doCmd(1'b1, 1'b1, 1'b0, 1'b0, 17'd66, 16'h7777, bc);
        nChecks++;
        if (FM_RD !== 16'h0002 || bc !== 6) begin
            nFail++; $display("[TB] FAIL ren_wen_read rd=%h busy=%0d exp 0002/6", FM_RD, bc);
        end
        readWord(17'd66, d, bc);
        nChecks++;
        if (d !== 16'h0002) begin nFail++; $display("[TB] FAIL ren_wen_write_dropped got=%h exp=0002", d); end
        // Hold a write request for the whole read; it must not start once busy drops.
        @(negedge FM_CLK);
        FM_ADDR = 17'd67; FM_REN = 1'b1;
        @(posedge FM_CLK);
        #1 FM_REN = 1'b0; FM_WEN = 1'b1; FM_WD = 16'h6666;
        for (int k = 0; k < 20; k++) begin
            @(negedge FM_CLK);
            if (!FM_BUSY) break;
        end
        FM_WEN = 1'b0;
        @(negedge FM_CLK);
        nChecks++;
        if (FM_BUSY !== 1'b0 || FM_RD !== 16'h0003) begin
            nFail++; $display("[TB] FAIL ignore_while_busy busy=%b rd=%h exp 0/0003", FM_BUSY, FM_RD);
        end
        readWord(17'd67, d, bc);
        nChecks++;
        if (d !== 16'h0003) begin nFail++; $display("[TB] FAIL ignored_write_absent got=%h exp=0003", d); end
    endtask

    task automatic test_reset_during_prog;
        int bc;
        writeWord(17'd128, 16'h9999, bc);
        @(negedge FM_CLK);
        FM_ADDR = 17'd128; FM_PROGRAM = 1'b1;
        @(posedge FM_CLK);
        #1 FM_PROGRAM = 1'b0;
        repeat (10) @(negedge FM_CLK);
        nChecks++;
        if (FM_BUSY !== 1'b1) begin nFail++; $display("[TB] FAIL prog_copy_busy got=%b exp=1", FM_BUSY); end
        reset = 1'b1;
        @(negedge FM_CLK);
        reset = 1'b0;
        nChecks++;
        if (FM_BUSY !== 1'b0 || FM_STATUS !== 2'b00 || FM_RD !== 16'h0) begin
            nFail++; $display("[TB] FAIL reset_abort busy=%b status=%b rd=%h exp 0/00/0000", FM_BUSY, FM_STATUS, FM_RD);
        end
        progPage(17'd128, bc);
        nChecks++;
        if (FM_STATUS !== 2'b10) begin nFail++; $display("[TB] FAIL reset_clears_dirty got=%b exp=10", FM_STATUS); end
    endtask

    task automatic test_alias;
        int bc; logic [15:0] d;
        writeWord(17'h10046, 16'h4242, bc);
        progPage(17'h10046, bc);
        readWord(17'd70, d, bc);
        nChecks++;
        if (d !== 16'h4242) begin nFail++; $display("[TB] FAIL addr_alias got=%h exp=4242", d); end
    endtask

`ifdef FM_EMU_PAGESTATUS_EN
    task automatic test_pagestatus;
        int bc;
        writeWord(17'd64, 16'h0001, bc);
        doCmd(1'b0, 1'b0, 1'b0, 1'b1, 17'd0, 16'h0, bc);
        nChecks++;
        if (FM_RD !== 16'h8001 || bc !== 1) begin
            nFail++; $display("[TB] FAIL pagestatus_dirty rd=%h busy=%0d exp 8001/1", FM_RD, bc);
        end
        progPage(17'd64, bc);
        doCmd(1'b0, 1'b0, 1'b0, 1'b1, 17'd0, 16'h0, bc);
        nChecks++;
        if (FM_RD !== 16'h0001) begin nFail++; $display("[TB] FAIL pagestatus_clean rd=%h exp=0001", FM_RD); end
    endtask
`endif

    initial begin
        test_reset;
        test_write_read_buffer;
        test_program_page;
        test_conflict;
        test_program_errors;
        test_priority;
        test_reset_during_prog;
        test_alias;
`ifdef FM_EMU_PAGESTATUS_EN
        test_pagestatus;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
